// File: rtl/seq_detect_param_if.sv
// Serial-stream and configuration bundle for seq_detect_param.
// master drives the bit stream and pattern load; slave returns the match pulse and count.
interface seq_detect_param_if #(
   parameter int unsigned PAT_LEN = 4,
   parameter int unsigned CNT_W   = 8
);
   logic               x;
   logic               x_valid;
   logic               overlap;
   logic               cfg_load;
   logic [PAT_LEN-1:0] cfg_pat;
   logic               y;
   logic [CNT_W-1:0]   match_cnt;

   modport master (
      output x, x_valid, overlap, cfg_load, cfg_pat,
      input  y, match_cnt
   );

   modport slave (
      input  x, x_valid, overlap, cfg_load, cfg_pat,
      output y, match_cnt
   );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial pattern detector with runtime-loadable pattern.
// Optional saturating match counter enabled by defining SEQDET_CNT_EN.
module seq_detect_param #(
   parameter int unsigned          PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0]   DEF_PAT = PAT_LEN'(4'b1011),
   parameter int unsigned          CNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   seq_detect_param_if.slave   bus
);

   localparam int unsigned       FILL_W   = $clog2(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

   logic [PAT_LEN-2:0] hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [PAT_LEN-1:0] pat_q,  pat_d;
   logic [PAT_LEN-1:0] window;
   logic               hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= '0;
         fill_q <= '0;
         pat_q  <= DEF_PAT;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
      end
   end

   // fill only counts buffered bits; the sliding window covers every alignment
   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      window = {hist_q, bus.x};
      hit    = bus.x_valid & ~bus.cfg_load & (fill_q == FILL_MAX) & (window == pat_q);

      if (bus.cfg_load) begin
         pat_d  = bus.cfg_pat;
         fill_d = '0;
         hist_d = '0;
      end else if (bus.x_valid) begin
         hist_d = window[PAT_LEN-2:0];
         if (hit) begin
            fill_d = bus.overlap ? FILL_MAX : '0;
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
         end
      end
   end

   assign bus.y = hit;

`ifdef SEQDET_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (bus.cfg_load) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign bus.match_cnt = cnt_q;
`else
   assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: directed scenarios then randomized traffic,
// checked against a bit-queue reference model.
module tb_seq_detect_param;

   localparam int unsigned PAT_LEN = 4;
   localparam int unsigned CNT_W   = 2;
   localparam int          CNT_MAX = 3;
`ifdef SEQDET_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      logic       y;
      logic [1:0] cnt;
      int         id;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   step_id;
   exp_t sb[$];

   // reference model state: valid bits since last clear, current pattern, count
   bit         bits_m[$];
   logic [3:0] pat_m;
   int         cnt_m;

   seq_detect_param_if #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) bus ();

   seq_detect_param #(
      .PAT_LEN (PAT_LEN),
      .DEF_PAT (4'b1011),
      .CNT_W   (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (bus.y !== e.y) begin
            failures++;
            $display("FAIL y step=%0d got=%b exp=%b", e.id, bus.y, e.y);
         end
         checks++;
         if (bus.match_cnt !== e.cnt) begin
            failures++;
            $display("FAIL match_cnt step=%0d got=%0d exp=%0d", e.id, bus.match_cnt, e.cnt);
         end
      end
   end

   function automatic void model_reset();
      bits_m.delete();
      pat_m = 4'b1011;
      cnt_m = 0;
   endfunction

   task automatic do_reset();
      exp_t e;
      rst          = 1'b0;
      bus.x        = 1'b1;
      bus.x_valid  = 1'b1;
      bus.overlap  = 1'b1;
      bus.cfg_load = 1'b0;
      bus.cfg_pat  = '0;
      e.y = 1'b0; e.cnt = 2'd0; e.id = step_id++;
      sb.push_back(e);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic step(input logic xi, input logic vi, input logic ovi,
                       input logic ldi, input logic [3:0] pi);
      exp_t       e;
      logic [3:0] w;
      logic       ey;
      int         n;
      bus.x        = xi;
      bus.x_valid  = vi;
      bus.overlap  = ovi;
      bus.cfg_load = ldi;
      bus.cfg_pat  = pi;
      ey = 1'b0;
      n  = bits_m.size();
      if (vi && !ldi && n >= 3) begin
         w  = {bits_m[n-3], bits_m[n-2], bits_m[n-1], xi};
         ey = (w == pat_m);
      end
      e.y = ey; e.cnt = 2'(cnt_m); e.id = step_id++;
      sb.push_back(e);
      if (ldi) begin
         pat_m = pi;
         bits_m.delete();
         cnt_m = 0;
      end else if (vi) begin
         bits_m.push_back(xi);
         if (bits_m.size() > 8) void'(bits_m.pop_front());
         if (ey && !ovi) bits_m.delete();
         if (ey && CNT_EN && cnt_m < CNT_MAX) cnt_m++;
      end
      @(posedge clk); #1;
   endtask

   task automatic send_bits(input logic [31:0] bits, input int n, input logic ov);
      logic [31:0] b;
      b = bits;
      for (int i = n - 1; i >= 0; i--) step(b[i], 1'b1, ov, 1'b0, 4'b0000);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      step_id  = 0;
      rst          = 1'b0;
      bus.x        = 1'b0;
      bus.x_valid  = 1'b0;
      bus.overlap  = 1'b0;
      bus.cfg_load = 1'b0;
      bus.cfg_pat  = '0;
      model_reset();
      @(posedge clk); #1;

      // T1 / T2: overlapping vs non-overlapping on default pattern
      do_reset();
      send_bits(32'b1011011, 7, 1'b1);
      do_reset();
      send_bits(32'b1011011, 7, 1'b0);
      send_bits(32'b1011, 4, 1'b0);

      // T3: invalid gap inside a partial match
      do_reset();
      send_bits(32'b101, 3, 1'b1);
      for (int i = 0; i < 5; i++) step(1'(i), 1'b0, 1'b1, 1'b0, 4'b0000);
      send_bits(32'b1, 1, 1'b1);

      // T4: reload mid-stream discards the concurrent bit
      do_reset();
      send_bits(32'b10, 2, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
      send_bits(32'b0110110, 7, 1'b1);

      // T5: reset mid-sequence restores default and clears history
      do_reset();
      send_bits(32'b101, 3, 1'b1);
      do_reset();
      send_bits(32'b1, 1, 1'b1);
      send_bits(32'b1011, 4, 1'b1);

      // T6: all-ones pattern, overlapping, counter saturation
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
      send_bits(32'b111111, 6, 1'b1);
      send_bits(32'b1, 1, 1'b1);
      send_bits(32'b1, 1, 1'b0);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 800; i++) begin
         int unsigned r;
         r = $urandom_range(0, 99);
         if (r == 0) begin
            do_reset();
         end else if (r < 5) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 4'($urandom_range(0, 15)));
         end else begin
            step(1'($urandom), ($urandom_range(0, 9) < 8), 1'($urandom), 1'b0, 4'($urandom));
         end
      end

      @(negedge clk); #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
